hazard_ctrl_unit: RTL

Parametrised successor to the forwarding-only hazard unit of the 5-stage RISC-V pipeline. It provides forwarding selects for the execute stage, load-use stalls, branch-taken flushes, and multi-cycle execute stalls for MUL/DIV ops. A cycle counter holds the execute stage for a configurable latency. Saturating performance counters record stall and flush cycles. It sits beside the stage modules in the pipeline top and drives their stall/flush inputs.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mc_stall_counter.sv | 60 ++++++
 rtl/hazard_ctrl_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard control unit.
package hazard_pkg;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Multi-cycle execute tracker state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/mc_stall_counter.sv
// Tracks how long a multi-cycle op has occupied Execute and requests stalls until its last cycle.
module mc_stall_counter
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic multiE,
    output logic mc,
    output logic mcBusy
);

    localparam int unsigned CNT_BITS = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam int unsigned LAST     = MC_LAT - 1;

    logic [CNT_BITS-1:0] mcCnt;
    logic                atLast;
    mc_state_t           state;
    mc_state_t           stateNext;

    assign atLast = (mcCnt == CNT_BITS'(LAST));

    // Occupancy counter: advances while stalling, clears on the final cycle or when the op leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            mcCnt <= '0;
        end else if (multiE && mc) begin
            mcCnt <= mcCnt + CNT_BITS'(1);
        end else begin
            mcCnt <= '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: enter BUSY on a stall request, leave on the final cycle or when the op drops
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (mc) stateNext = BUSY;
            BUSY: if (!multiE || atLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs: stall request from the live count, busy flag from the state
    always_comb begin
        mc     = multiE && !atLast;
        mcBusy = (state == BUSY);
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: forwarding, load-use / multi-cycle stalls, branch flushes, perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              result_src_e,
    input  logic              pc_src_e,
    input  logic              multi_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic mc;
    logic lu;
    logic unusedRegWriteE;

    // A load always writes its destination, so the Execute write enable adds nothing to load-use
    assign unusedRegWriteE = reg_write_e;

    mc_stall_counter #(
        .MC_LAT (MC_LAT)
    ) uMcStall (
        .clk    (clk),
        .rst    (rst),
        .multiE (multi_e),
        .mc     (mc),
        .mcBusy (mc_busy)
    );

    // Operand forwarding: Memory beats Writeback, x0 is never forwarded
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (!rst) begin
            if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      forward_a_e = FWD_MEM;
            else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) forward_a_e = FWD_WB;
            if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      forward_b_e = FWD_MEM;
            else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) forward_b_e = FWD_WB;
        end
    end

    // Load in Execute feeding an instruction in Decode
    assign lu = result_src_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Stall/flush priority: taken branch, then multi-cycle hold, then load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (mc) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Saturating stall/flush cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_e && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
